demux1to4_8bit_buf: RTL
=======================

# demux1to4_8bit_buf

Buffered 1-to-4 byte demultiplexer: the sending side's counterpart to the 8-bit 4-to-1 selector. The selector merges four byte lanes onto one; this block takes one byte stream and steers each byte to one of four output lanes. The lane is chosen by the same two select bits, `sel1` and `sel0`. Each lane has a small FIFO with a valid/ready handshake, so a stalled lane does not lose data.

## Interface
- `WIDTH`, 8, data width of the input and of every output lane.
- `DEPTH`, 2, entries per lane FIFO; power of two, ≥2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset. Asynchronous assert, active-low; release is synchronous to `clk` in the surrounding design.
- `sel1` input 1: lane select MSB.
- `sel0` input 1: lane select LSB. Lane = {sel1,sel0}: 00→o0, 01→o1, 10→o2, 11→o3.
- `d` input WIDTH: input byte.
- `in_valid` input 1: `d`/`sel1`/`sel0` are valid.
- `in_ready` output 1: the block accepts the input this cycle.
- `o0`, `o1`, `o2`, `o3` output WIDTH each: head entry of the lane FIFO.
- `o_valid` output 4: bit k set when lane k's FIFO is non-empty.
- `o_ready` input 4: bit k set when the lane k consumer takes the head entry.
- `lane_full` output 4: bit k set when lane k's FIFO holds DEPTH entries.

## Operation
- Accept: `in_valid & in_ready` at a rising edge writes `d` into the FIFO of the selected lane.
- `in_ready = !lane_full[{sel1,sel0}]`.
  - Combinational from `sel` and registered state only.
  - No path from `o_ready` to `in_ready`.
- Pop: `o_valid[k] & o_ready[k]` at a rising edge removes lane k's head entry.
  - Lanes pop independently; all four may pop in the same cycle as a push.
- Push and pop on the same lane, same cycle:
  - Not full: occupancy unchanged, and both the write and the head advance take effect.
  - Full: `in_ready` is 0, so only the pop occurs. No write-through when full.
- `o_valid[k] = 0` → `ok` drives 0 (no stale data on the outputs).
- Output order within a lane is strict arrival order. There is no ordering relation between lanes.
- `o_ready[k]` asserted while `o_valid[k]=0` is ignored.
- Holding rule: `sel1`, `sel0` and `d` must stay stable while `in_valid=1 & in_ready=0`; the bench asserts this. Lowering `in_valid` without an accept is allowed.
- Per-lane pointers: `wr_ptr` and `rd_ptr` are log2(DEPTH)+1 bits each, wrapping modulo 2·DEPTH.
  - Empty: pointers equal.
  - Full: the MSBs differ and the remaining bits are equal.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - All pointers → 0.
  - `o_valid` → 4'b0000, `o0`–`o3` → 0, `lane_full` → 0.
  - `in_ready` → 1 for any `sel`.
- Reset mid-operation discards all buffered bytes immediately, without waiting for a clock edge.
- Latency: a byte accepted at edge N is visible on `ok` with `o_valid[k]=1` after edge N; there is no combinational bypass from `d`.
- Throughput: 1 byte/cycle sustained into any single lane whose consumer holds `o_ready` high.
- `lane_full[k]` rises after the edge that writes the DEPTH-th entry. It falls after the first edge with a pop and no push on lane k.

## Structure
- Shared package `demux_pkg`:
  - `NUM_LANES` = 4.
  - Lane index type, 2 bits.
  - Lane encoding constants `LANE0`..`LANE3`, matching the selector's `{sel1,sel0}` mapping so the demux→mux round trip is identity.
- Sub-module `byte_fifo`, parameterised by WIDTH and DEPTH:
  - Ports: `clk`, `rst_n`, `wr_en`, `wr_data`, `rd_en`, `rd_data`, `empty`, `full`.
  - Instantiated once per lane.
- Top level: select decode to per-lane `wr_en`, plus output gating.

## Test plan
- Basic steering: after reset, send 8'b01100010 @00, 8'b00000000 @01, 8'b11111111 @10, 8'b10101010 @11 on consecutive cycles with `o_ready`=4'b1111.
  - Each byte appears on `o0`..`o3` respectively, one cycle after its accept.
  - Only the matching `o_valid` bit is set.
- Backpressure: `o_ready[2]`=0; push 0x11, 0x22, 0x33 to lane 10.
  - First two accepted; `lane_full[2]`=1; `in_ready`=0 on the third.
  - Raise `o_ready[2]`: outputs 0x11 then 0x22; 0x33 is accepted on the cycle after the first pop.
- Non-blocking lanes: with lane 2 full, switch `sel` to 01 and push 0x44.
  - Accepted immediately; `o1`=0x44 next cycle.
  - Lane 2 contents are unchanged.
- Simultaneous push/pop: lane 0 holds 1 entry with `o_ready[0]`=1; push 0x5A every cycle for 8 cycles.
  - `in_ready` stays 1; the output stream is in order and `o_valid[0]` stays 1.
- Full + pop: lane 3 full with `o_ready[3]`=1 and `in_valid`=1 to lane 3.
  - Only the pop occurs; the push is accepted the next cycle.
- Async reset mid-stream: assert `rst_n`=0 between edges with data in all lanes.
  - `o_valid`=0 and `o0`–`o3`=0 immediately; `in_ready`=1.
  - After release, the first byte pushed to lane 1 is the first byte out of lane 1.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the buffered 1-to-4 byte demultiplexer.
//   NUM_LANES    number of output lanes
//   lane_t       2-bit lane index, {sel1,sel0}
//   LANE0..LANE3 lane encodings; these match the 4-to-1 selector's mapping so
//                a demux -> mux round trip with the same select is identity.
package demux_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_t;

  localparam lane_t LANE0 = 2'b00;
  localparam lane_t LANE1 = 2'b01;
  localparam lane_t LANE2 = 2'b10;
  localparam lane_t LANE3 = 2'b11;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: small synchronous FIFO, one per output lane.
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset; empties the FIFO
//   wr_en    push wr_data (ignored when full)
//   wr_data  data to push
//   rd_en    pop the head entry (ignored when empty)
//   rd_data  head entry; undefined content when empty, the caller gates it
//   empty    no entries held
//   full     DEPTH entries held
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  // Full: wrap bits differ, index bits equal.
  assign full  = (wr_ptr_reg == {~rd_ptr_reg[AW], rd_ptr_reg[AW-1:0]});

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // Storage needs no reset: resetting the pointers makes every entry dead.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  // Head is read straight from storage so a write is visible right after
  // its edge; it is never a bypass of the current input.
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/demux1to4_8bit_buf.sv
// demux1to4_8bit_buf: buffered 1-to-4 byte demultiplexer.
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset; discards all buffered bytes
//   sel1,sel0  lane select {sel1,sel0}: 00->o0, 01->o1, 10->o2, 11->o3
//   d          input byte
//   in_valid   d/sel are valid
//   in_ready   selected lane has room; depends on sel and registered state only
//   o0..o3     lane head bytes, 0 when the lane is empty
//   o_valid    bit k: lane k non-empty
//   o_ready    bit k: lane k consumer takes the head entry
//   lane_full  bit k: lane k holds DEPTH entries
module demux1to4_8bit_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sel1,
  input  logic                 sel0,
  input  logic [WIDTH-1:0]     d,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     o0,
  output logic [WIDTH-1:0]     o1,
  output logic [WIDTH-1:0]     o2,
  output logic [WIDTH-1:0]     o3,
  output logic [NUM_LANES-1:0] o_valid,
  input  logic [NUM_LANES-1:0] o_ready,
  output logic [NUM_LANES-1:0] lane_full
);

  lane_t                lane_sel;
  logic [NUM_LANES-1:0] wr_en;
  logic [NUM_LANES-1:0] rd_en;
  logic [NUM_LANES-1:0] empty_w;
  logic [NUM_LANES-1:0] full_w;
  logic [WIDTH-1:0]     head_w  [NUM_LANES];
  logic [WIDTH-1:0]     lane_out[NUM_LANES];

  assign lane_sel  = lane_t'({sel1, sel0});
  // Only the selected lane's full flag matters; o_ready never reaches here,
  // so a pop on a full lane frees the slot for the following cycle.
  assign in_ready  = ~full_w[lane_sel];
  assign o_valid   = ~empty_w;
  assign lane_full = full_w;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign wr_en[gi] = in_valid & in_ready & (lane_sel == lane_t'(gi));
      assign rd_en[gi] = o_ready[gi] & ~empty_w[gi];

      byte_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en[gi]),
        .wr_data (d),
        .rd_en   (rd_en[gi]),
        .rd_data (head_w[gi]),
        .empty   (empty_w[gi]),
        .full    (full_w[gi])
      );

      // Empty lanes drive zero so no stale byte is ever presented.
      assign lane_out[gi] = empty_w[gi] ? '0 : head_w[gi];
    end
  endgenerate

  assign o0 = lane_out[LANE0];
  assign o1 = lane_out[LANE1];
  assign o2 = lane_out[LANE2];
  assign o3 = lane_out[LANE3];

endmodule
